// File: rtl/print_arbiter.sv
// print_arbiter: shares one UART print engine among NUM_REQ requesters using
// round-robin arbitration. The winning message is latched, one start strobe is
// sent to the engine, and no new grant is made until the engine has taken the
// message and gone idle again, or has failed to take it within ACCEPT_TIMEOUT.
module print_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int MSG_BYTES      = 16,
  parameter int ACCEPT_TIMEOUT = 15
) (
  input  logic                           print_clk,
  input  logic                           print_rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_type,
  input  logic [NUM_REQ*8-1:0]           req_len,
  input  logic [NUM_REQ*MSG_BYTES*8-1:0] req_data,
  output logic                           pr_start,
  output logic                           pr_type,
  output logic [7:0]                     pr_len,
  output logic [MSG_BYTES*8-1:0]         pr_data,
  input  logic                           pr_idle,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           busy,
  output logic [7:0]                     err_cnt
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(ACCEPT_TIMEOUT + 1);
  localparam int DW  = MSG_BYTES * 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_ACC  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  // Returns {found, index}: first valid requester after ptr, wrapping around.
  function automatic logic [IDW:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                           input logic [IDW-1:0]     ptr);
    logic [IDW:0] res;
    int           idx;
    res = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      res = (!res[IDW] && valid[IDW'(idx)]) ? {1'b1, IDW'(idx)} : res;
    end
    return res;
  endfunction

  // Returns {clamped, length}: STR messages carry no length, bad HEX lengths clamp.
  function automatic logic [8:0] len_rule(input logic typ, input logic [7:0] len);
    logic [8:0] res;
    if (typ == 1'b0) begin
      res = {1'b0, 8'h00};
    end else if ((len == 8'h00) || (len > 8'(MSG_BYTES))) begin
      res = {1'b1, 8'(MSG_BYTES)};
    end else begin
      res = {1'b0, len};
    end
    return res;
  endfunction

  state_t           state_r, state_nxt_s;
  logic [IDW-1:0]   ptr_r;
  logic [CW-1:0]    cnt_r, cnt_nxt_s;
  logic [IDW:0]     pick_s;
  logic             pick_found_s;
  logic [IDW-1:0]   pick_idx_s;
  logic [8:0]       pick_len_s;
  logic [DW-1:0]    pick_data_s;
  logic             grant_s;
  logic             timeout_s;
  logic             err_inc_s;

  logic [NUM_REQ-1:0] req_ready_r;
  logic               pr_start_r;
  logic               pr_type_r;
  logic [7:0]         pr_len_r;
  logic [DW-1:0]      pr_data_r;
  logic [IDW-1:0]     grant_id_r;
  logic               busy_r;
  logic [7:0]         err_cnt_r;

  // Select the round-robin winner and fetch its type/length/payload slices.
  always_comb begin
    pick_s       = rr_pick(req_valid, ptr_r);
    pick_found_s = pick_s[IDW];
    pick_idx_s   = pick_s[IDW-1:0];
    pick_len_s   = len_rule(req_type[pick_idx_s], req_len[8*int'(pick_idx_s) +: 8]);
    pick_data_s  = req_data[DW*int'(pick_idx_s) +: DW];
  end

  // Next-state logic: grant, issue, wait for acceptance, wait for completion.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    grant_s     = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pr_idle && pick_found_s) begin
          grant_s     = 1'b1;
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_nxt_s   = '0;
        state_nxt_s = ST_WAIT_ACC;
      end
      ST_WAIT_ACC: begin
        if (!pr_idle) begin
          state_nxt_s = ST_WAIT_DONE;
        end else if (cnt_r == CW'(ACCEPT_TIMEOUT - 1)) begin
          // Engine never took the message: drop it and free the arbiter.
          timeout_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          cnt_nxt_s   = cnt_r + CW'(1'b1);
        end
      end
      ST_WAIT_DONE: begin
        if (pr_idle) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_DONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    err_inc_s = (grant_s && pick_len_s[8]) || timeout_s;
  end

  // State register, round-robin pointer and accept-timeout counter.
  always_ff @(posedge print_clk) begin
    if (print_rst) begin
      state_r <= ST_IDLE;
      ptr_r   <= IDW'(NUM_REQ - 1);
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (grant_s) begin
        ptr_r <= pick_idx_s;
      end
    end
  end

  // Registered outputs: strobes for the issue cycle, latched message, error count.
  always_ff @(posedge print_clk) begin
    if (print_rst) begin
      req_ready_r <= '0;
      pr_start_r  <= 1'b0;
      pr_type_r   <= 1'b0;
      pr_len_r    <= 8'h00;
      pr_data_r   <= '0;
      grant_id_r  <= '0;
      busy_r      <= 1'b0;
      err_cnt_r   <= 8'h00;
    end else begin
      pr_start_r  <= grant_s;
      req_ready_r <= grant_s ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx_s) : '0;
      busy_r      <= (state_nxt_s != ST_IDLE);
      if (grant_s) begin
        pr_type_r  <= req_type[pick_idx_s];
        pr_len_r   <= pick_len_s[7:0];
        pr_data_r  <= pick_data_s;
        grant_id_r <= pick_idx_s;
      end
      if (err_inc_s && (err_cnt_r != 8'hFF)) begin
        err_cnt_r <= err_cnt_r + 8'h01;
      end
    end
  end

  assign req_ready = req_ready_r;
  assign pr_start  = pr_start_r;
  assign pr_type   = pr_type_r;
  assign pr_len    = pr_len_r;
  assign pr_data   = pr_data_r;
  assign grant_id  = grant_id_r;
  assign busy      = busy_r;
  assign err_cnt   = err_cnt_r;

endmodule
